// File: rtl/scaler_cfg_sched.sv
`default_nettype none
// ============================================================================
//  Module      : scaler_cfg_sched
//  Description : Frame-synchronous configuration scheduler for the scaler.
//                Host writes land in shadow registers; a commit request is
//                held until both the scaler input (vs_i) and output (vs_o)
//                are between frames, then all shadows are copied to the
//                active registers in a single cycle. This keeps a frame from
//                being scaled with mixed settings. Completed output frames
//                (vs_o falling edges) are counted for status.
//
//  Ports       : clk, rst                  clock, synchronous active-high reset
//                wr_en/wr_addr/wr_data     host shadow write (addr 3 ignored)
//                commit_i                  request shadow -> active transfer
//                vs_i, vs_o                scaler input/output frame-active
//                reg_h_scale_step          active horizontal step
//                reg_v_scale_step          active vertical step
//                reg_v_scale_inline_size   active inline size
//                pending_o                 commit accepted, not yet applied
//                applied_o                 one-cycle pulse on the apply cycle
//                frame_cnt_o               completed output frame count
//                cfg_err_o                 sticky range error
//
//  Build macro : SCALER_CFG_RANGE_CHECK_EN
//                Defined   - steps clamped to [STEP_MIN, STEP_MAX], inline
//                            size 0 replaced by 1, any clamp sets cfg_err_o.
//                Undefined - values copied unmodified, cfg_err_o stays 0.
//
//  Revision    : 1.0  initial release
// ============================================================================
module scaler_cfg_sched #(
    parameter int REG_WIDTH  = 16,
    parameter int SCALE_STEP = 128,
    parameter int INLINE_RST = 12,
    parameter int STEP_MIN   = 32,
    parameter int STEP_MAX   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [1:0]           wr_addr,
    input  logic [REG_WIDTH-1:0] wr_data,
    input  logic                 commit_i,
    input  logic                 vs_i,
    input  logic                 vs_o,
    output logic [REG_WIDTH-1:0] reg_h_scale_step,
    output logic [REG_WIDTH-1:0] reg_v_scale_step,
    output logic [REG_WIDTH-1:0] reg_v_scale_inline_size,
    output logic                 pending_o,
    output logic                 applied_o,
    output logic [15:0]          frame_cnt_o,
    output logic                 cfg_err_o
);

    localparam logic [REG_WIDTH-1:0] c_STEP_RST   = REG_WIDTH'(SCALE_STEP);
    localparam logic [REG_WIDTH-1:0] c_INLINE_RST = REG_WIDTH'(INLINE_RST);
    localparam logic [REG_WIDTH-1:0] c_STEP_MIN   = REG_WIDTH'(STEP_MIN);
    localparam logic [REG_WIDTH-1:0] c_STEP_MAX   = REG_WIDTH'(STEP_MAX);
    localparam logic [REG_WIDTH-1:0] c_INLINE_MIN = REG_WIDTH'(1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_PENDING = 2'd1;
    localparam logic [1:0] c_ST_APPLY   = 2'd2;

`ifdef SCALER_CFG_RANGE_CHECK_EN
    localparam logic c_RANGE_CHECK = 1'b1;
`else
    localparam logic c_RANGE_CHECK = 1'b0;
`endif

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;

    logic [REG_WIDTH-1:0] r_sh_h;
    logic [REG_WIDTH-1:0] r_sh_v;
    logic [REG_WIDTH-1:0] r_sh_inline;
    logic [REG_WIDTH-1:0] r_act_h;
    logic [REG_WIDTH-1:0] r_act_v;
    logic [REG_WIDTH-1:0] r_act_inline;

    logic [REG_WIDTH-1:0] w_h_apply;
    logic [REG_WIDTH-1:0] w_v_apply;
    logic [REG_WIDTH-1:0] w_inline_apply;
    logic                 w_clamp_any;

    logic                 r_vs_o_d;
    logic [15:0]          r_frame_cnt;
    logic                 r_cfg_err;

    // ------------------------------------------------------------------
    // Commit FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Commit FSM: next state and status outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        pending_o    = 1'b0;
        applied_o    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (commit_i) begin
                    w_state_next = c_ST_PENDING;
                end
            end
            c_ST_PENDING: begin
                pending_o = 1'b1;
                // Further commits are absorbed here; one apply covers them all.
                if (!vs_i && !vs_o) begin
                    w_state_next = c_ST_APPLY;
                end
            end
            c_ST_APPLY: begin
                applied_o = 1'b1;
                // A commit landing on the apply cycle must not be lost: the
                // shadow may already hold newer data than what is being applied.
                w_state_next = commit_i ? c_ST_PENDING : c_ST_IDLE;
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Apply-value selection. The clamp path is always built so the range
    // parameters stay referenced; without the range-check macro the
    // select is constant and the clamp logic folds away.
    // ------------------------------------------------------------------
    always_comb begin
        w_h_apply      = r_sh_h;
        w_v_apply      = r_sh_v;
        w_inline_apply = r_sh_inline;
        w_clamp_any    = 1'b0;
        if (c_RANGE_CHECK) begin
            if (r_sh_h < c_STEP_MIN) begin
                w_h_apply   = c_STEP_MIN;
                w_clamp_any = 1'b1;
            end else if (r_sh_h > c_STEP_MAX) begin
                w_h_apply   = c_STEP_MAX;
                w_clamp_any = 1'b1;
            end
            if (r_sh_v < c_STEP_MIN) begin
                w_v_apply   = c_STEP_MIN;
                w_clamp_any = 1'b1;
            end else if (r_sh_v > c_STEP_MAX) begin
                w_v_apply   = c_STEP_MAX;
                w_clamp_any = 1'b1;
            end
            if (r_sh_inline == '0) begin
                w_inline_apply = c_INLINE_MIN;
                w_clamp_any    = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers: writable in any state. A write on the apply cycle
    // updates the shadow only; the active copy takes the pre-write value
    // because both are sampled at the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_h      <= c_STEP_RST;
            r_sh_v      <= c_STEP_RST;
            r_sh_inline <= c_INLINE_RST;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0:    r_sh_h      <= wr_data;
                2'd1:    r_sh_v      <= wr_data;
                2'd2:    r_sh_inline <= wr_data;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Active registers: touched only by reset or the apply cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_act_h      <= c_STEP_RST;
            r_act_v      <= c_STEP_RST;
            r_act_inline <= c_INLINE_RST;
            r_cfg_err    <= 1'b0;
        end else if (r_state == c_ST_APPLY) begin
            r_act_h      <= w_h_apply;
            r_act_v      <= w_v_apply;
            r_act_inline <= w_inline_apply;
            if (w_clamp_any) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output frame counter (vs_o falling edge), free-running and wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_o_d    <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_vs_o_d <= vs_o;
            if (r_vs_o_d && !vs_o) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign reg_h_scale_step        = r_act_h;
    assign reg_v_scale_step        = r_act_v;
    assign reg_v_scale_inline_size = r_act_inline;
    assign frame_cnt_o             = r_frame_cnt;
    assign cfg_err_o               = r_cfg_err;

endmodule
`default_nettype wire
